// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake with a
// fixed, parameterised response latency and alignment/range error reporting.
//
// state   | meaning
// IDLE    | ready for a request; accepting one latches it
// WAIT    | latency countdown for the latched request
// RESP    | response held on the outputs until the initiator takes it
module dmem_responder #(
  parameter int AddressWidth = 10,
  parameter int WaitCycles   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0]  CntInit   = (WaitCycles > 0) ? 4'(WaitCycles - 1) : 4'd0;
  localparam logic [63:0] AddrLimit = 64'd1 << (AddressWidth + 2);

  logic [1:0]  state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [2**AddressWidth];

  logic                    accept;
  logic                    enter_resp;
  logic                    acc_we;
  logic [31:0]             acc_addr;
  logic [31:0]             acc_wdata;
  logic [3:0]              acc_be;
  logic                    acc_err;
  logic [AddressWidth-1:0] acc_idx;
  logic                    do_write;

  // With zero wait cycles the access happens on the acceptance edge itself, so the
  // storage port is fed straight from the request inputs while in IDLE.
  always_comb begin
    accept     = 1'b0;
    enter_resp = 1'b0;
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    acc_be     = be_q;
    if (state_q == ST_IDLE) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_be_i;
      accept    = req_valid_i & rst_i;
      enter_resp = accept && (WaitCycles == 0);
    end else if (state_q == ST_WAIT) begin
      enter_resp = rst_i && (cnt_q == 4'd0);
    end
    acc_err  = (acc_addr[1:0] != 2'b00) || ({32'd0, acc_addr} >= AddrLimit);
    acc_idx  = acc_addr[AddressWidth+1:2];
    do_write = enter_resp && acc_we && !acc_err;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            cnt_q   <= CntInit;
            state_q <= (WaitCycles == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (enter_resp) begin
        err_q   <= acc_err;
        rdata_q <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
      end
    end
  end

  // Storage is deliberately not reset so it can map onto a plain RAM macro.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) && rst_i;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'd0;
  assign rsp_err_o   = rsp_valid_o ? err_q : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with two wait cycles, one with none, sharing clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_valid = 1'b0, a_ready, a_we = 1'b0, a_rsp_valid, a_rsp_ready = 1'b0, a_rsp_err;
  logic [31:0] a_addr = '0, a_wdata = '0, a_rsp_rdata;
  logic [3:0]  a_be = '0;

  logic        b_valid = 1'b0, b_ready, b_we = 1'b0, b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_err;
  logic [31:0] b_addr = '0, b_wdata = '0, b_rsp_rdata;
  logic [3:0]  b_be = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.AddressWidth(10), .WaitCycles(2)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_be_i(a_be),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
  );

  dmem_responder #(.AddressWidth(10), .WaitCycles(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_be_i(b_be),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
  );

  // Full transaction on dut_a. lat counts edges from the acceptance edge (counted as 1)
  // up to the edge after which rsp_valid is first seen. Inputs are scrambled after acceptance.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output int lat, output logic [31:0] rd,
                      output logic er);
    @(negedge clk);
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    a_valid = 1'b0; a_we = ~we; a_addr = 32'hFFFF_FFFF; a_wdata = 32'h0BAD_0BAD; a_be = 4'hF;
    while (!a_rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rd = a_rsp_rdata;
    er = a_rsp_err;
    a_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0 || a_rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a_outputs: got valid=%b rdata=%h err=%b, want 0/00000000/0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err);
    end
    n_cmp++;
    if (b_rsp_valid !== 1'b0 || b_rsp_rdata !== 32'd0 || b_rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b_outputs: got valid=%b rdata=%h err=%b, want 0/00000000/0",
               b_rsp_valid, b_rsp_rdata, b_rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got a=%b b=%b, want 1/1", a_ready, b_ready);
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, er);
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL store_latency: got %0d, want 3", lat); end
    n_cmp++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      n_bad++; $display("FAIL store_rsp: got rdata=%h err=%b, want 00000000/0", rd, er);
    end
    xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL load_latency: got %0d, want 3", lat); end
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      n_bad++; $display("FAIL load_data: got rdata=%h err=%b, want deadbeef/0", rd, er);
    end
    n_cmp++;
    if (a_rsp_valid !== 1'b0 || a_ready !== 1'b1) begin
      n_bad++; $display("FAIL after_complete: got valid=%b ready=%b, want 0/1", a_rsp_valid, a_ready);
    end
  endtask

  task automatic test_byte_enable();
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 32'h10, 32'h0000_0011, 4'b0001, lat, rd, er);
    xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'hDEAD_BE11) begin n_bad++; $display("FAIL be_0001: got %h, want deadbe11", rd); end
    xact(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, lat, rd, er);
    n_cmp++;
    if (er !== 1'b0 || rd !== 32'd0) begin
      n_bad++; $display("FAIL be_0000_rsp: got rdata=%h err=%b, want 00000000/0", rd, er);
    end
    xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'hDEAD_BE11) begin n_bad++; $display("FAIL be_0000_noop: got %h, want deadbe11", rd); end
    xact(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0110, lat, rd, er);
    xact(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'hDEBB_CC11) begin n_bad++; $display("FAIL be_0110: got %h, want debbcc11", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    xact(1'b0, 32'h12, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_bad++; $display("FAIL misaligned_load: got rdata=%h err=%b, want 00000000/1", rd, er);
    end
    xact(1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      n_bad++; $display("FAIL range_load: got rdata=%h err=%b, want 00000000/1", rd, er);
    end
    xact(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, lat, rd, er);
    xact(1'b1, 32'h1000, 32'h1111_1111, 4'hF, lat, rd, er);
    n_cmp++;
    if (er !== 1'b1) begin n_bad++; $display("FAIL range_store_err: got %b, want 1", er); end
    xact(1'b1, 32'h2, 32'h2222_2222, 4'hF, lat, rd, er);
    n_cmp++;
    if (er !== 1'b1) begin n_bad++; $display("FAIL misaligned_store_err: got %b, want 1", er); end
    xact(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      n_bad++; $display("FAIL word0_intact: got rdata=%h err=%b, want cafef00d/0", rd, er);
    end
    xact(1'b1, 32'hFFC, 32'h5A5A_5A5A, 4'hF, lat, rd, er);
    xact(1'b0, 32'hFFC, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'h5A5A_5A5A || er !== 1'b0) begin
      n_bad++; $display("FAIL top_word: got rdata=%h err=%b, want 5a5a5a5a/0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    int waited = 0;
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    while (!a_rsp_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'hDEBB_CC11 || a_rsp_err !== 1'b0 || a_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b, want 1/debbcc11/0/0",
                 i, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_ready);
      end
      @(negedge clk);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    a_rsp_ready = 1'b0;
    n_cmp++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0 || a_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: got valid=%b rdata=%h ready=%b, want 0/00000000/1",
               a_rsp_valid, a_rsp_rdata, a_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 32'h20, 32'h0F0F_0F0F, 4'hF, lat, rd, er);
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234_5678; a_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0 || a_rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_wait_outputs: got valid=%b rdata=%h err=%b, want 0/00000000/0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    xact(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    n_cmp++;
    if (rd !== 32'h0F0F_0F0F) begin
      n_bad++; $display("FAIL reset_wait_store_dropped: got %h, want 0f0f0f0f", rd);
    end
    // A held response must vanish as soon as reset asserts, without a clock edge.
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b0; a_addr = 32'h20;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 32'h0F0F_0F0F) begin
      n_bad++; $display("FAIL resp_before_reset: got valid=%b rdata=%h, want 1/0f0f0f0f", a_rsp_valid, a_rsp_rdata);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'd0 || a_rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_resp_outputs: got valid=%b rdata=%h err=%b, want 0/00000000/0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [31:0] exp_rdata [3];
    logic        exp_err   [3];
    req_we[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 32'hA5A5_A5A5; exp_rdata[0] = 32'd0;        exp_err[0] = 1'b0;
    req_we[1] = 1'b0; req_addr[1] = 32'h40; req_wdata[1] = 32'h0;         exp_rdata[1] = 32'hA5A5_A5A5; exp_err[1] = 1'b0;
    req_we[2] = 1'b0; req_addr[2] = 32'h42; req_wdata[2] = 32'h0;         exp_rdata[2] = 32'd0;        exp_err[2] = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b1;
    b_valid = 1'b1; b_be = 4'hF;
    b_we = req_we[0]; b_addr = req_addr[0]; b_wdata = req_wdata[0];
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (b_ready !== ((i % 2) == 0) || b_rsp_valid !== ((i % 2) == 1)) begin
        n_bad++;
        $display("FAIL b2b_handshake[%0d]: got ready=%b rsp_valid=%b, want %b/%b",
                 i, b_ready, b_rsp_valid, (i % 2) == 0, (i % 2) == 1);
      end
      if ((i % 2) == 1) begin
        n_cmp++;
        if (b_rsp_rdata !== exp_rdata[i/2] || b_rsp_err !== exp_err[i/2]) begin
          n_bad++;
          $display("FAIL b2b_rsp[%0d]: got rdata=%h err=%b, want %h/%b",
                   i / 2, b_rsp_rdata, b_rsp_err, exp_rdata[i/2], exp_err[i/2]);
        end
        if (i < 5) begin
          b_we = req_we[(i+1)/2]; b_addr = req_addr[(i+1)/2]; b_wdata = req_wdata[(i+1)/2];
        end else begin
          b_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    b_rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter AddressWidth, default 10, word-address width of the internal storage (2**AddressWidth 32-bit words).
REQ-002 Parameter WaitCycles, default 2, range 0..15, cycles between request acceptance and response.
REQ-003 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 req_valid_i  input  1  initiator presents a request.
REQ-006 req_ready_o  output  1  responder can accept a request this cycle.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data, little-endian lanes.
REQ-010 req_be_i  input  4  store byte enables, bit n gates wdata[8n+7:8n].
REQ-011 rsp_valid_o  output  1  response available.
REQ-012 rsp_ready_i  input  1  initiator accepts response.
REQ-013 rsp_rdata_o  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err_o  output  1  request was misaligned or out of range.

Function
REQ-015 State machine SHALL have states IDLE, WAIT, RESP.
REQ-016 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i & req_ready_o at a rising edge.
REQ-017 On acceptance, we, addr, wdata, be SHALL be captured into internal registers; inputs may change afterwards without effect.
REQ-018 On acceptance: WaitCycles>0 -> WAIT with counter loaded to WaitCycles-1; WaitCycles=0 -> RESP directly next cycle.
REQ-019 In WAIT, counter SHALL decrement each cycle; at counter=0 the next edge SHALL enter RESP.
REQ-020 Storage access (read or write) SHALL occur on the edge entering RESP; response latency from acceptance edge = WaitCycles+1 edges.
REQ-021 Error SHALL be flagged when captured addr[1:0]!=0 or any of addr[31:AddressWidth+2] is 1; errored stores SHALL not modify storage.
REQ-022 Stores SHALL update only enabled byte lanes; be=0000 is a legal no-op store, err=0.
REQ-023 Loads SHALL return the full word at addr[AddressWidth+1:2]; rsp_rdata_o=0 whenever rsp_err_o=1 or request was a store.
REQ-024 In RESP, rsp_valid_o=1 and rsp_rdata_o/rsp_err_o SHALL be stable until rsp_ready_i=1 at an edge, then IDLE.
REQ-025 rsp_valid_o SHALL be 0 outside RESP; rsp_rdata_o and rsp_err_o SHALL be 0 outside RESP.
REQ-026 No new request accepted in the cycle the response completes (one IDLE cycle minimum between responses).
REQ-027 Load after store to same word SHALL return post-store data.

Reset
REQ-028 While rst_i=0: state=IDLE, counter=0, req_ready_o=1 (once released), rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0; outputs take reset values immediately, not at next edge.
REQ-029 Reset mid-WAIT SHALL discard the pending request; an uncommitted store SHALL not modify storage.
REQ-030 Storage contents SHALL not be cleared by reset; contents are undefined until written.

Verification
REQ-031 WaitCycles=2: store addr 0x10, wdata 0xDEADBEEF, be 1111; then load 0x10 -> rsp_valid 3 edges after each acceptance, rdata 0xDEADBEEF, err 0.
REQ-032 Byte enables: after REQ-031, store 0x10 wdata 0x00000011 be 0001; load -> 0xDEADBE11.
REQ-033 Misaligned load 0x12 and out-of-range load 0x1000 (AddressWidth=10) -> err 1, rdata 0; store to 0x1000 leaves word 0 unchanged.
REQ-034 Backpressure: hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid, rdata, err stable; req_ready_o=0 throughout; completion on first rsp_ready_i=1.
REQ-035 Reset mid-WAIT of store 0x20 wdata 0x12345678 -> outputs at reset values immediately; subsequent load 0x20 returns prior contents, not 0x12345678.
REQ-036 WaitCycles=0: back-to-back requests with req_valid_i held 1 -> acceptance every 2 edges (rsp_ready_i=1), response one edge after acceptance.
